// File: rtl/goldschmidt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : goldschmidt_seq
//  Description : Handshaked sequencer for the shared Goldschmidt divider
//                datapath. Accepts one divide request on a valid/ready
//                channel, registers the operands, steps the datapath through
//                its init and refinement cycles via mode/stage selects,
//                captures the quotient and offers it on a valid/ready result
//                channel with backpressure.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH  operand / quotient width (fixed point, matches datapath)
//    ITERS  refinement iterations (>= 1), each one N cycle plus one D cycle
//
//  Ports
//    clk             clock
//    reset           synchronous, active-high reset
//    in_valid        request valid
//    in_ready        sequencer can accept a request (IDLE only)
//    in_num          normalised numerator
//    in_den          normalised denominator
//    dp_mode         datapath mode : 0 = multiply by k0, 1 = multiply by k
//    dp_stage        datapath stage: 0 = update n,       1 = update d,k
//    dp_numerator    registered numerator to datapath
//    dp_denominator  registered denominator to datapath
//    dp_quotient     datapath n register (quotient estimate)
//    out_valid       result valid
//    out_ready       consumer accepts result
//    out_quotient    captured quotient
//    out_dbz         divide-by-zero flag for this result
//    busy            high in any state other than IDLE
//
//  Timing (acceptance cycle = cycle 0)
//    cycle 1              INIT_N   (0,0)
//    cycle 2              INIT_D   (0,1)
//    cycles 3..2+2*ITERS  ITER_N (1,0) / ITER_D (1,1) pairs
//    cycle 3+2*ITERS      DONE, out_valid high
//    divide by zero       DONE in cycle 1, no datapath cycles
// ============================================================================
module goldschmidt_seq #(
  parameter int WIDTH = 29,
  parameter int ITERS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic             dp_mode,
  output logic             dp_stage,
  output logic [WIDTH-1:0] dp_numerator,
  output logic [WIDTH-1:0] dp_denominator,
  input  logic [WIDTH-1:0] dp_quotient,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic             out_dbz,
  output logic             busy
);

  localparam int                 ITC_W    = $clog2(ITERS + 1);
  localparam logic [ITC_W-1:0]   LAST_ITC = ITC_W'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_N = 3'd1,
    S_INIT_D = 3'd2,
    S_ITER_N = 3'd3,
    S_ITER_D = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  logic [ITC_W-1:0] r_itc;

  // All outputs are registered. The selects, in_ready and busy are loaded
  // with the decode of the state being entered, so at every cycle they equal
  // a pure function of the current state:
  //   IDLE/DONE (1,1)  INIT_N (0,0)  INIT_D (0,1)  ITER_N (1,0)  ITER_D (1,1)
  // (1,1) in IDLE/DONE holds the datapath n register so an idle datapath
  // never disturbs n.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_itc          <= '0;
      out_valid      <= 1'b0;
      out_quotient   <= '0;
      out_dbz        <= 1'b0;
      dp_numerator   <= '0;
      dp_denominator <= '0;
      dp_mode        <= 1'b1;
      dp_stage       <= 1'b1;
      in_ready       <= 1'b1;
      busy           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone completes
          // the handshake here.
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_den != '0) begin
              dp_numerator   <= in_num;
              dp_denominator <= in_den;
              r_itc          <= '0;
              r_state        <= S_INIT_N;
              dp_mode        <= 1'b0;
              dp_stage       <= 1'b0;
            end else begin
              // Zero divisor: saturate, flag, and skip the datapath
              // entirely. Selects remain at the hold encoding.
              r_state      <= S_DONE;
              out_quotient <= '1;
              out_dbz      <= 1'b1;
              out_valid    <= 1'b1;
            end
          end
        end

        S_INIT_N: begin
          r_state  <= S_INIT_D;
          dp_mode  <= 1'b0;
          dp_stage <= 1'b1;
        end

        S_INIT_D: begin
          r_state  <= S_ITER_N;
          dp_mode  <= 1'b1;
          dp_stage <= 1'b0;
        end

        S_ITER_N: begin
          r_state  <= S_ITER_D;
          dp_mode  <= 1'b1;
          dp_stage <= 1'b1;
        end

        S_ITER_D: begin
          if (r_itc == LAST_ITC) begin
            // n was last written on the ITER_N edge, so the value visible
            // during this final ITER_D cycle is the finished quotient.
            r_state      <= S_DONE;
            out_quotient <= dp_quotient;
            out_dbz      <= 1'b0;
            out_valid    <= 1'b1;
            dp_mode      <= 1'b1;
            dp_stage     <= 1'b1;
          end else begin
            r_itc    <= r_itc + 1'b1;
            r_state  <= S_ITER_N;
            dp_mode  <= 1'b1;
            dp_stage <= 1'b0;
          end
        end

        S_DONE: begin
          // Result and flag are held until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_itc     <= '0;
          out_valid <= 1'b0;
          dp_mode   <= 1'b1;
          dp_stage  <= 1'b1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_goldschmidt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_goldschmidt_seq
//  Description : Self-checking bench for goldschmidt_seq. Two instances
//                (ITERS=6 and ITERS=1) are checked every cycle against a
//                transaction-level model that works from the age of the
//                current request, plus literal expectations at key cycles.
//                The datapath stub drives dp_quotient with the number of
//                cycles since acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_goldschmidt_seq;

  localparam int W = 29;

  typedef struct {
    bit           active;
    bit           dbz;
    int           age;
    logic [W-1:0] num;
    logic [W-1:0] den;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ITERS=6 instance
  logic         v6 = 1'b0, rdy6, dm6, ds6, ov6, ordy6 = 1'b0, dbz6, busy6;
  logic [W-1:0] n6 = '0, d6 = '0, dpn6, dpd6, oq6, rel6 = '0;
  // ITERS=1 instance
  logic         v1 = 1'b0, rdy1, dm1, ds1, ov1, ordy1 = 1'b1, dbz1, busy1;
  logic [W-1:0] n1 = '0, d1 = '0, dpn1, dpd1, oq1, rel1 = '0;

  goldschmidt_seq #(.WIDTH(W), .ITERS(6)) u_dut6 (
    .clk(clk), .reset(rst), .in_valid(v6), .in_ready(rdy6),
    .in_num(n6), .in_den(d6), .dp_mode(dm6), .dp_stage(ds6),
    .dp_numerator(dpn6), .dp_denominator(dpd6), .dp_quotient(rel6),
    .out_valid(ov6), .out_ready(ordy6), .out_quotient(oq6),
    .out_dbz(dbz6), .busy(busy6)
  );

  goldschmidt_seq #(.WIDTH(W), .ITERS(1)) u_dut1 (
    .clk(clk), .reset(rst), .in_valid(v1), .in_ready(rdy1),
    .in_num(n1), .in_den(d1), .dp_mode(dm1), .dp_stage(ds1),
    .dp_numerator(dpn1), .dp_denominator(dpd1), .dp_quotient(rel1),
    .out_valid(ov1), .out_ready(ordy1), .out_quotient(oq1),
    .out_dbz(dbz1), .busy(busy1)
  );

  // Datapath stub: cycles elapsed since the last accepted request.
  always @(posedge clk) begin
    rel6 <= (v6 && rdy6) ? W'(1) : rel6 + 1'b1;
    rel1 <= (v1 && rdy1) ? W'(1) : rel1 + 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Select pattern by age: 1 -> (0,0), 2 -> (0,1), then alternating
  // (1,0)/(1,1) for the iterations; (1,1) whenever not sequencing.
  function automatic logic [1:0] exp_sel(input int iters, input mdl_t m);
    int seq_len;
    seq_len = 2 + 2 * iters;
    if (m.active && !m.dbz && m.age <= seq_len) begin
      if (m.age == 1) return 2'b00;
      if (m.age == 2) return 2'b01;
      return (((m.age - 3) % 2) == 0) ? 2'b10 : 2'b11;
    end
    return 2'b11;
  endfunction

  task automatic model_step(
    input string tag, input int iters, input mdl_t m, input bit en,
    input logic rst_i, input logic iv, input logic ir,
    input logic [W-1:0] inum, input logic [W-1:0] iden,
    input logic dmode, input logic dstage,
    input logic [W-1:0] dnum, input logic [W-1:0] dden,
    input logic ov, input logic ordy, input logic [W-1:0] oq,
    input logic odbz, input logic bsy,
    output mdl_t mn
  );
    int           seq_len;
    logic         exp_ov;
    logic [1:0]   es;
    logic [W-1:0] eq;
    seq_len = 2 + 2 * iters;
    exp_ov  = m.active && (m.dbz || m.age > seq_len);
    es      = exp_sel(iters, m);
    eq      = m.dbz ? {W{1'b1}} : W'(seq_len);
    if (en) begin
      chk({tag, ".in_ready"}, 64'(ir), 64'(!m.active));
      chk({tag, ".busy"}, 64'(bsy), 64'(m.active));
      chk({tag, ".dp_mode"}, 64'(dmode), 64'(es[1]));
      chk({tag, ".dp_stage"}, 64'(dstage), 64'(es[0]));
      chk({tag, ".dp_numerator"}, 64'(dnum), 64'(m.num));
      chk({tag, ".dp_denominator"}, 64'(dden), 64'(m.den));
      chk({tag, ".out_valid"}, 64'(ov), 64'(exp_ov));
      if (exp_ov) begin
        chk({tag, ".out_quotient"}, 64'(oq), 64'(eq));
        chk({tag, ".out_dbz"}, 64'(odbz), 64'(m.dbz));
      end
    end
    mn = m;
    if (rst_i) begin
      mn.active = 1'b0;
      mn.dbz    = 1'b0;
      mn.age    = 0;
      mn.num    = '0;
      mn.den    = '0;
    end else if (!m.active) begin
      if (iv) begin
        mn.active = 1'b1;
        mn.age    = 1;
        mn.dbz    = (iden == '0);
        if (iden != '0) begin
          mn.num = inum;
          mn.den = iden;
        end
      end
    end else if (exp_ov && ordy) begin
      mn.active = 1'b0;
    end else begin
      mn.age = m.age + 1;
    end
  endtask

  mdl_t m6 = '{1'b0, 1'b0, 0, '0, '0};
  mdl_t m1 = '{1'b0, 1'b0, 0, '0, '0};
  mdl_t nx6, nx1;

  // Compare on the falling edge, then advance the model to the next cycle
  // using the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    model_step("i6", 6, m6, armed, rst, v6, rdy6, n6, d6, dm6, ds6, dpn6, dpd6,
               ov6, ordy6, oq6, dbz6, busy6, nx6);
    model_step("i1", 1, m1, armed, rst, v1, rdy1, n1, d1, dm1, ds1, dpn1, dpd1,
               ov1, ordy1, oq1, dbz1, busy1, nx1);
    m6 = nx6;
    m1 = nx1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int acc;

  initial begin
    step(3);
    rst   = 1'b0;
    armed = 1'b1;

    // Reset state
    chk("rst.in_ready", 64'(rdy6), 64'd1);
    chk("rst.out_valid", 64'(ov6), 64'd0);
    chk("rst.sel", 64'({dm6, ds6}), 64'b11);
    chk("rst.busy", 64'(busy6), 64'd0);
    chk("rst.out_quotient", 64'(oq6), 64'd0);
    chk("rst.out_dbz", 64'(dbz6), 64'd0);
    chk("rst.dp_numerator", 64'(dpn6), 64'd0);

    // Normal divide on both instances, accepted in cycle 0
    v6 = 1'b1; n6 = 29'h0800_0000; d6 = 29'h0C00_0000;
    v1 = 1'b1; n1 = 29'h5; d1 = 29'h7;
    step(1);  // cycle 1
    v6 = 1'b0; v1 = 1'b0;
    chk("c1.sel6", 64'({dm6, ds6}), 64'b00);
    chk("c1.sel1", 64'({dm1, ds1}), 64'b00);
    chk("c1.dp_num6", 64'(dpn6), 64'h0800_0000);
    step(1);  // cycle 2
    chk("c2.sel6", 64'({dm6, ds6}), 64'b01);
    chk("c2.sel1", 64'({dm1, ds1}), 64'b01);
    step(1);  // cycle 3
    chk("c3.sel6", 64'({dm6, ds6}), 64'b10);
    chk("c3.sel1", 64'({dm1, ds1}), 64'b10);
    step(1);  // cycle 4
    chk("c4.sel1", 64'({dm1, ds1}), 64'b11);
    chk("c4.ov1", 64'(ov1), 64'd0);
    step(1);  // cycle 5
    chk("c5.ov1", 64'(ov1), 64'd1);
    chk("c5.oq1", 64'(oq1), 64'd4);
    step(9);  // cycle 14
    chk("c14.sel6", 64'({dm6, ds6}), 64'b11);
    chk("c14.ov6", 64'(ov6), 64'd0);
    step(1);  // cycle 15
    chk("c15.ov6", 64'(ov6), 64'd1);
    chk("c15.oq6", 64'(oq6), 64'd14);
    chk("c15.dbz6", 64'(dbz6), 64'd0);
    chk("c15.in_ready6", 64'(rdy6), 64'd0);

    // Backpressure: out_ready low for 5 cycles of out_valid
    step(5);  // cycle 20
    chk("bp.ov6", 64'(ov6), 64'd1);
    chk("bp.oq6", 64'(oq6), 64'd14);
    chk("bp.in_ready6", 64'(rdy6), 64'd0);
    ordy6 = 1'b1;
    step(1);
    chk("bp.release.in_ready6", 64'(rdy6), 64'd1);
    chk("bp.release.ov6", 64'(ov6), 64'd0);
    ordy6 = 1'b0;

    // Divide by zero
    v6 = 1'b1; n6 = 29'h123; d6 = 29'h0;
    step(1);  // cycle 1
    v6 = 1'b0;
    chk("dbz.ov6", 64'(ov6), 64'd1);
    chk("dbz.oq6", 64'(oq6), 64'h1FFF_FFFF);
    chk("dbz.flag6", 64'(dbz6), 64'd1);
    chk("dbz.sel6", 64'({dm6, ds6}), 64'b11);
    chk("dbz.dp_num6", 64'(dpn6), 64'h0800_0000);
    step(1);
    ordy6 = 1'b1;
    step(1);
    chk("dbz.release.ov6", 64'(ov6), 64'd0);

    // Throughput: in_valid held for 40 cycles, numerator changing each cycle
    acc = 0;
    v6  = 1'b1; d6 = 29'h0C00_0000;
    for (int i = 0; i < 40; i++) begin
      n6 = W'(32'h100 + i);
      if (rdy6) acc++;
      step(1);
    end
    v6 = 1'b0;
    chk("tput.acceptances", 64'(acc), 64'd3);
    step(16);

    // Reset during ITER_N (cycle 7)
    v6 = 1'b1; n6 = 29'hABC; d6 = 29'h1;
    step(1);
    v6 = 1'b0;
    step(6);  // cycle 7
    chk("rmid.c7.sel6", 64'({dm6, ds6}), 64'b10);
    rst = 1'b1;
    step(1);  // cycle 8
    rst = 1'b0;
    chk("rmid.in_ready6", 64'(rdy6), 64'd1);
    chk("rmid.ov6", 64'(ov6), 64'd0);
    chk("rmid.sel6", 64'({dm6, ds6}), 64'b11);
    chk("rmid.busy6", 64'(busy6), 64'd0);

    // Fresh request after the reset completes with normal latency
    v6 = 1'b1; n6 = 29'h777; d6 = 29'h999;
    step(1);
    v6 = 1'b0;
    step(13); // cycle 14
    chk("post.c14.ov6", 64'(ov6), 64'd0);
    step(1);  // cycle 15
    chk("post.c15.ov6", 64'(ov6), 64'd1);
    chk("post.c15.oq6", 64'(oq6), 64'd14);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
